// File: rtl/glb_core_strm_wr_sink.sv
// Stream-router write sink: keeps writes addressed to this tile, buffers them in a small FIFO
// and issues them to the bank write port with valid/ready. Dropped hit writes are counted.
module glb_core_strm_wr_sink #(
    parameter int DATA_W      = 64,
    parameter int STRB_W      = 8,
    parameter int BANK_ADDR_W = 17,
    parameter int TILE_SEL_W  = 5,
    parameter int ADDR_W      = 22,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic [TILE_SEL_W-1:0]  glb_tile_id,
    input  logic                   strm_wr_en,
    input  logic [ADDR_W-1:0]      strm_wr_addr,
    input  logic [STRB_W-1:0]      strm_wr_strb,
    input  logic [DATA_W-1:0]      strm_wr_data,
    output logic                   bank_wr_valid,
    input  logic                   bank_wr_ready,
    output logic [BANK_ADDR_W-1:0] bank_wr_addr,
    output logic [STRB_W-1:0]      bank_wr_strb,
    output logic [DATA_W-1:0]      bank_wr_data,
    input  logic                   cfg_clear,
    output logic                   sts_overflow,
    output logic [7:0]             sts_drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = BANK_ADDR_W + STRB_W + DATA_W;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             hit, empty, full;
    logic             push_req, push, pop, drop;
    logic [ENT_W-1:0] head;

    assign hit = strm_wr_en
               & (strm_wr_addr[ADDR_W-1:BANK_ADDR_W] == glb_tile_id)
               & (|strm_wr_strb);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                 & (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_req = clk_en & hit;
    assign pop      = clk_en & ~empty & bank_wr_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (clk_en && cfg_clear) begin
            ovf_d = 1'b0;
            cnt_d = 8'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage carries no reset; the empty mask keeps stale entries off the port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {strm_wr_addr[BANK_ADDR_W-1:0], strm_wr_strb, strm_wr_data};
        end
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    assign bank_wr_valid = ~empty;
    assign bank_wr_addr  = head[ENT_W-1 -: BANK_ADDR_W];
    assign bank_wr_strb  = head[DATA_W +: STRB_W];
    assign bank_wr_data  = head[DATA_W-1:0];
    assign sts_overflow  = ovf_q;
    assign sts_drop_cnt  = cnt_q;

endmodule

// File: tb/tb_glb_core_strm_wr_sink.sv
// Directed bench for glb_core_strm_wr_sink: one task per scenario, inline comparisons.
module tb_glb_core_strm_wr_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [4:0]  glb_tile_id;
    logic        strm_wr_en;
    logic [21:0] strm_wr_addr;
    logic [7:0]  strm_wr_strb;
    logic [63:0] strm_wr_data;
    logic        bank_wr_valid;
    logic        bank_wr_ready;
    logic [16:0] bank_wr_addr;
    logic [7:0]  bank_wr_strb;
    logic [63:0] bank_wr_data;
    logic        cfg_clear;
    logic        sts_overflow;
    logic [7:0]  sts_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    glb_core_strm_wr_sink dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .glb_tile_id(glb_tile_id),
        .strm_wr_en(strm_wr_en), .strm_wr_addr(strm_wr_addr), .strm_wr_strb(strm_wr_strb),
        .strm_wr_data(strm_wr_data), .bank_wr_valid(bank_wr_valid), .bank_wr_ready(bank_wr_ready),
        .bank_wr_addr(bank_wr_addr), .bank_wr_strb(bank_wr_strb), .bank_wr_data(bank_wr_data),
        .cfg_clear(cfg_clear), .sts_overflow(sts_overflow), .sts_drop_cnt(sts_drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one active edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] tile, input logic [16:0] la,
                          input logic [7:0] strb, input logic [63:0] data);
        strm_wr_en   = en;
        strm_wr_addr = {tile, la};
        strm_wr_strb = strb;
        strm_wr_data = data;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_en = 1'b1; glb_tile_id = 5'd3; bank_wr_ready = 1'b0; cfg_clear = 1'b0;
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        tick(); tick();
        reset = 1'b0;
        if (bank_wr_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        if (bank_wr_addr !== 17'h0) begin $display("FAIL reset_addr: got %h want 0", bank_wr_addr); n_err++; end
        n_cmp++;
        if (bank_wr_data !== 64'h0) begin $display("FAIL reset_data: got %h want 0", bank_wr_data); n_err++; end
        n_cmp++;
        if (sts_overflow !== 1'b0) begin $display("FAIL reset_ovf: got %b want 0", sts_overflow); n_err++; end
        n_cmp++;
        if (sts_drop_cnt !== 8'd0) begin $display("FAIL reset_cnt: got %0d want 0", sts_drop_cnt); n_err++; end
        n_cmp++;
    endtask

    task automatic test_single_hit();
        bank_wr_ready = 1'b1;
        set_wr(1'b1, 5'd3, 17'h00100, 8'hFF, 64'hA5);
        tick();
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        if (bank_wr_valid !== 1'b1) begin $display("FAIL single_valid: got %b want 1", bank_wr_valid); n_err++; end
        n_cmp++;
        if (bank_wr_addr !== 17'h00100) begin $display("FAIL single_addr: got %h want 00100", bank_wr_addr); n_err++; end
        n_cmp++;
        if (bank_wr_strb !== 8'hFF) begin $display("FAIL single_strb: got %h want ff", bank_wr_strb); n_err++; end
        n_cmp++;
        if (bank_wr_data !== 64'hA5) begin $display("FAIL single_data: got %h want a5", bank_wr_data); n_err++; end
        n_cmp++;
        tick();
        if (bank_wr_valid !== 1'b0) begin $display("FAIL single_popped: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        if (bank_wr_data !== 64'h0) begin $display("FAIL single_idle_data: got %h want 0", bank_wr_data); n_err++; end
        n_cmp++;
    endtask

    task automatic test_filter();
        bank_wr_ready = 1'b0;
        set_wr(1'b1, 5'd4, 17'h00200, 8'hFF, 64'h11);
        tick();
        if (bank_wr_valid !== 1'b0) begin $display("FAIL filter_tile: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        set_wr(1'b1, 5'd3, 17'h00200, 8'h00, 64'h22);
        tick();
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        if (bank_wr_valid !== 1'b0) begin $display("FAIL filter_strb: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        tick();
        if (bank_wr_valid !== 1'b0) begin $display("FAIL filter_late: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        if (sts_drop_cnt !== 8'd0) begin $display("FAIL filter_cnt: got %0d want 0", sts_drop_cnt); n_err++; end
        n_cmp++;
    endtask

    task automatic test_full();
        bank_wr_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            set_wr(1'b1, 5'd3, 17'(i * 8), 8'h0F, 64'(i));
            tick();
        end
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        if (sts_overflow !== 1'b1) begin $display("FAIL full_ovf: got %b want 1", sts_overflow); n_err++; end
        n_cmp++;
        if (sts_drop_cnt !== 8'd2) begin $display("FAIL full_cnt: got %0d want 2", sts_drop_cnt); n_err++; end
        n_cmp++;
        tick();
        if (bank_wr_data !== 64'd1) begin $display("FAIL full_hold: got %h want 1", bank_wr_data); n_err++; end
        n_cmp++;
        bank_wr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (bank_wr_valid !== 1'b1 || bank_wr_data !== 64'(i) || bank_wr_addr !== 17'(i * 8)) begin
                $display("FAIL full_order[%0d]: got v=%b d=%h a=%h want v=1 d=%h a=%h",
                         i, bank_wr_valid, bank_wr_data, bank_wr_addr, 64'(i), 17'(i * 8));
                n_err++;
            end
            n_cmp++;
            tick();
        end
        if (bank_wr_valid !== 1'b0) begin $display("FAIL full_drained: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        if (sts_overflow !== 1'b0 || sts_drop_cnt !== 8'd0) begin
            $display("FAIL full_clear: got ovf=%b cnt=%0d want 0/0", sts_overflow, sts_drop_cnt); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        bank_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 5'd3, 17'h0, 8'hFF, 64'h10 + 64'(i));
            tick();
        end
        bank_wr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_wr(1'b1, 5'd3, 17'h0, 8'hFF, 64'h14 + 64'(k));
            if (bank_wr_valid !== 1'b1 || bank_wr_data !== 64'h10 + 64'(k)) begin
                $display("FAIL b2b_head[%0d]: got v=%b d=%h want v=1 d=%h",
                         k, bank_wr_valid, bank_wr_data, 64'h10 + 64'(k));
                n_err++;
            end
            n_cmp++;
            tick();
        end
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        if (sts_drop_cnt !== 8'd0 || sts_overflow !== 1'b0) begin
            $display("FAIL b2b_nodrop: got cnt=%0d ovf=%b want 0/0", sts_drop_cnt, sts_overflow); n_err++;
        end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            if (bank_wr_valid !== 1'b1 || bank_wr_data !== 64'h1A + 64'(k)) begin
                $display("FAIL b2b_tail[%0d]: got v=%b d=%h want v=1 d=%h",
                         k, bank_wr_valid, bank_wr_data, 64'h1A + 64'(k));
                n_err++;
            end
            n_cmp++;
            tick();
        end
        if (bank_wr_valid !== 1'b0) begin $display("FAIL b2b_occupancy: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
    endtask

    task automatic test_clk_en_clear_reset();
        bank_wr_ready = 1'b0;
        clk_en = 1'b0;
        set_wr(1'b1, 5'd3, 17'h40, 8'hFF, 64'h77);
        tick();
        clk_en = 1'b1;
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        tick();
        if (bank_wr_valid !== 1'b0) begin $display("FAIL clken_hit: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
        for (int i = 0; i < 304; i++) begin
            set_wr(1'b1, 5'd3, 17'h0, 8'h01, 64'(i));
            tick();
        end
        if (sts_drop_cnt !== 8'd255) begin $display("FAIL sat_cnt: got %0d want 255", sts_drop_cnt); n_err++; end
        n_cmp++;
        if (sts_overflow !== 1'b1) begin $display("FAIL sat_ovf: got %b want 1", sts_overflow); n_err++; end
        n_cmp++;
        clk_en = 1'b0; cfg_clear = 1'b1;
        tick();
        if (sts_drop_cnt !== 8'd255) begin $display("FAIL clken_clear: got %0d want 255", sts_drop_cnt); n_err++; end
        n_cmp++;
        clk_en = 1'b1;
        tick();
        cfg_clear = 1'b0;
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        if (sts_drop_cnt !== 8'd0 || sts_overflow !== 1'b0) begin
            $display("FAIL clear_wins: got cnt=%0d ovf=%b want 0/0", sts_drop_cnt, sts_overflow); n_err++;
        end
        n_cmp++;
        if (bank_wr_data !== 64'd0) begin $display("FAIL full_head: got %h want 0", bank_wr_data); n_err++; end
        n_cmp++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_wr(1'b1, 5'd3, 17'h80, 8'hF0, 64'hC0 + 64'(i));
            tick();
        end
        set_wr(1'b0, 5'd0, 17'h0, 8'h0, 64'h0);
        if (bank_wr_valid !== 1'b1 || bank_wr_data !== 64'hC0) begin
            $display("FAIL pre_reset: got v=%b d=%h want v=1 d=c0", bank_wr_valid, bank_wr_data); n_err++;
        end
        n_cmp++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (bank_wr_valid !== 1'b0 || bank_wr_data !== 64'h0) begin
            $display("FAIL reset_flush: got v=%b d=%h want v=0 d=0", bank_wr_valid, bank_wr_data); n_err++;
        end
        n_cmp++;
        bank_wr_ready = 1'b1;
        tick();
        if (bank_wr_valid !== 1'b0) begin $display("FAIL reset_stays_empty: got %b want 0", bank_wr_valid); n_err++; end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_filter();
        test_full();
        test_back_to_back();
        test_clk_en_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
